// File: rtl/apb_slave_regbank_pkg.sv
// Shared APB definitions: bus widths, slave FSM encodings and the ID register default.
// The width macros are shared with the APB master.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_slave_regbank_pkg;

    localparam int APB_ADDR_WIDTH = `ADDR_WIDTH;
    localparam int APB_DATA_WIDTH = `DATA_WIDTH;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    // Wide enough for WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regbank.sv
// APB3 slave holding a bank of word registers, with optional wait states, error responses
// and a write-strobe side port that reports every committed register update.
module apb_slave_regbank
    import apb_slave_regbank_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(ID_VALUE_DEFAULT),
    localparam int                   IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           pclk,
    input  logic                           reset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic                           wr_strobe,
    output logic [IDX_W-1:0]               wr_index,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

    apb_state_e            state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic                  write_q;
    logic                  err_q;
    logic [IDX_W-1:0]      index_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_strobe_q;
    logic [IDX_W-1:0]      wr_index_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  setup_req;
    logic [31:0]           addr_index;
    logic                  addr_err;
    logic                  last_cycle;
    logic                  capture;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rdata_d;

    // The live address is decoded only into the captured error flag, never into outputs.
    assign setup_req  = psel && !penable;
    assign addr_index = 32'(paddr[ADDR_WIDTH-1:2]);
    assign addr_err   = (paddr[1:0] != 2'b00)
                     || (addr_index >= 32'(NUM_REGS))
                     || (pwrite && (addr_index == 32'd0));

    assign last_cycle = (state_q == ACCESS) && (wait_cnt_q == WAIT_CNT_W'(WAIT_STATES));
    assign capture    = setup_req && ((state_q == IDLE) || last_cycle);
    assign commit     = last_cycle && psel && write_q && !err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE:    if (setup_req) state_q <= SETUP;
                SETUP:   state_q <= psel ? ACCESS : IDLE;
                ACCESS: begin
                    if (!psel)           state_q <= IDLE;
                    else if (!last_cycle) wait_cnt_q <= wait_cnt_q + 1'b1;
                    else                 state_q <= setup_req ? SETUP : IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (capture) begin
                write_q    <= pwrite;
                err_q      <= addr_err;
                index_q    <= addr_index[IDX_W-1:0];
                wdata_q    <= pwdata;
                wait_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            // NOTE: the bank is reset explicitly because its contents are architecturally
            // visible on reg_flat; this keeps it out of RAM macros, which is intended here.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            wr_strobe_q <= commit;
            if (commit) begin
                regs_q[index_q] <= wdata_q;
                wr_index_q      <= index_q;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        rdata_d = '0;
        if (index_q == '0) rdata_d = ID_VALUE;
        else               rdata_d = regs_q[index_q];
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_flat[i*DATA_WIDTH +: DATA_WIDTH] = (i == 0) ? ID_VALUE : regs_q[i];
        end
    end

    assign pready    = last_cycle;
    assign pslverr   = last_cycle && err_q;
    assign prdata    = (last_cycle && !write_q && !err_q) ? rdata_d : '0;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;

endmodule
